// File: rtl/tick_watchdog_pkg.sv
// Shared types and defaults for the tick watchdog: FSM state encoding,
// default gap window / lock parameters and the counter-width sanity check.
package tick_watchdog_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } wd_state_e;

    localparam int DEF_MIN_GAP  = 17400;
    localparam int DEF_MAX_GAP  = 17600;
    localparam int DEF_LOCK_CNT = 4;
    localparam int DEF_CBITS    = 15;
    localparam int DEF_TBITS    = 8;

    // The gap counter saturates at max_gap, so it must be able to hold that value.
    function automatic bit cbits_ok(input int cbits, input int max_gap);
        longint span;
        span = longint'(1) << cbits;
        return span > longint'(max_gap);
    endfunction

endpackage

// File: rtl/tick_watchdog_gap_timer.sv
// Gap counter for the tick watchdog: counts cycles since the last tick and
// classifies each tick (good/early) plus a timeout strobe when no tick arrives.
module tick_gap_timer
    import tick_watchdog_pkg::*;
#(
    parameter int MIN_GAP = DEF_MIN_GAP,
    parameter int MAX_GAP = DEF_MAX_GAP,
    parameter int CBITS   = DEF_CBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             run,
    output logic [CBITS-1:0] gap_cnt,
    output logic             good,
    output logic             early,
    output logic             timeout
);

    localparam logic [CBITS-1:0] MAX_CNT = CBITS'(MAX_GAP);
    localparam logic [CBITS:0]   MIN_W   = (CBITS+1)'(MIN_GAP);
    localparam logic [CBITS:0]   MAX_W   = (CBITS+1)'(MAX_GAP);

    logic [CBITS-1:0] gap_cnt_q;
    logic [CBITS-1:0] gap_cnt_d;
    logic [CBITS:0]   gap;

    // The gap of a tick is one more than the count; widened so MAX_GAP+1 fits.
    always_comb begin
        gap     = {1'b0, gap_cnt_q} + (CBITS+1)'(1);
        good    = tick && (gap >= MIN_W) && (gap <= MAX_W);
        early   = tick && (gap < MIN_W);
        timeout = !tick && (gap_cnt_q == MAX_CNT);

        if (!run || tick) begin
            gap_cnt_d = '0;
        end else if (gap_cnt_q == MAX_CNT) begin
            gap_cnt_d = gap_cnt_q;
        end else begin
            gap_cnt_d = gap_cnt_q + CBITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign gap_cnt = gap_cnt_q;

endmodule

// File: rtl/tick_watchdog.sv
// Tick watchdog: acquires lock after LOCK_CNT in-window tick gaps, then raises a
// sticky fault on an early or missing tick until clr.
module tick_watchdog
    import tick_watchdog_pkg::*;
#(
    parameter int MIN_GAP  = DEF_MIN_GAP,
    parameter int MAX_GAP  = DEF_MAX_GAP,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int CBITS    = DEF_CBITS,
    parameter int TBITS    = DEF_TBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr,
    output logic             locked,
    output logic             fault,
    output logic             early,
    output logic             late,
    output logic [CBITS-1:0] gap_cnt,
    output logic [TBITS-1:0] tick_count
);

    localparam int GBITS = $clog2(LOCK_CNT + 1);
    localparam logic [GBITS-1:0] LOCK_LAST = GBITS'(LOCK_CNT - 1);
    localparam logic [GBITS-1:0] LOCK_FULL = GBITS'(LOCK_CNT);

    if (!cbits_ok(CBITS, MAX_GAP)) begin : g_cbits_too_small
        $error("tick_watchdog: CBITS too narrow to hold MAX_GAP");
    end
    if (MIN_GAP > MAX_GAP) begin : g_bad_window
        $error("tick_watchdog: MIN_GAP exceeds MAX_GAP");
    end

    wd_state_e        state_q, state_d;
    logic [GBITS-1:0] good_cnt_q, good_cnt_d;
    logic [TBITS-1:0] tick_count_q, tick_count_d;
    logic             locked_q, locked_d;
    logic             fault_q, fault_d;
    logic             early_q, early_d;
    logic             late_q, late_d;

    logic             gap_good;
    logic             gap_early;
    logic             gap_timeout;
    logic             timer_run;

    // Counting only continues into states that measure gaps; IDLE/FAULT hold it at 0.
    assign timer_run = (state_d == ACQUIRE) || (state_d == LOCKED);

    tick_gap_timer #(
        .MIN_GAP (MIN_GAP),
        .MAX_GAP (MAX_GAP),
        .CBITS   (CBITS)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .run     (timer_run),
        .gap_cnt (gap_cnt),
        .good    (gap_good),
        .early   (gap_early),
        .timeout (gap_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            good_cnt_q   <= '0;
            tick_count_q <= '0;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
            early_q      <= 1'b0;
            late_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            tick_count_q <= tick_count_d;
            locked_q     <= locked_d;
            fault_q      <= fault_d;
            early_q      <= early_d;
            late_q       <= late_d;
        end
    end

    // A tick whose gap is exactly MAX_GAP+1 is neither good nor early and leaves the state alone.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (tick) state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    if (gap_good && (good_cnt_q == LOCK_LAST)) state_d = LOCKED;
                    else if (gap_timeout)                      state_d = IDLE;
                end
                LOCKED: begin
                    if (gap_early || gap_timeout) state_d = FAULT;
                end
                FAULT: begin
                    state_d = FAULT;
                end
            endcase
        end
    end

    always_comb begin
        good_cnt_d   = good_cnt_q;
        tick_count_d = tick_count_q;
        early_d      = 1'b0;
        late_d       = 1'b0;
        if (clr) begin
            good_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    good_cnt_d = '0;
                end
                ACQUIRE: begin
                    if (gap_good) begin
                        good_cnt_d = (good_cnt_q == LOCK_LAST) ? LOCK_FULL : good_cnt_q + GBITS'(1);
                    end else if (gap_early) begin
                        early_d    = 1'b1;
                        good_cnt_d = '0;
                    end else if (gap_timeout) begin
                        late_d     = 1'b1;
                        good_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (gap_good)    tick_count_d = tick_count_q + TBITS'(1);
                    if (gap_early)   early_d = 1'b1;
                    if (gap_timeout) late_d  = 1'b1;
                end
                FAULT: begin
                    good_cnt_d = good_cnt_q;
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
        fault_d  = (state_d == FAULT);
    end

    assign locked     = locked_q;
    assign fault      = fault_q;
    assign early      = early_q;
    assign late       = late_q;
    assign tick_count = tick_count_q;

endmodule

// File: tb/tb_tick_watchdog.sv
// Self-checking bench for tick_watchdog: directed scenarios with literal
// expectations plus randomized ticks checked every cycle against a timestamp model.
module tb_tick_watchdog;

    localparam int MIN_GAP  = 8;
    localparam int MAX_GAP  = 12;
    localparam int LOCK_CNT = 3;
    localparam int CBITS    = 4;
    localparam int TBITS    = 4;

    localparam int M_IDLE  = 0;
    localparam int M_ACQ   = 1;
    localparam int M_LOCK  = 2;
    localparam int M_FAULT = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick = 1'b0;
    logic             clr = 1'b0;
    logic             locked;
    logic             fault;
    logic             early;
    logic             late;
    logic [CBITS-1:0] gap_cnt;
    logic [TBITS-1:0] tick_count;

    int tests = 0;
    int fails = 0;

    // Model state: mode, cycle stamp of the last tick, good-gap tally, counters.
    int cyc = 0;
    int m_mode = M_IDLE;
    int m_last = 0;
    int m_goods = 0;
    int m_tc = 0;
    int m_early = 0;
    int m_late = 0;
    int m_gap_out = 0;
    bit model_valid = 1'b0;

    tick_watchdog #(
        .MIN_GAP    (MIN_GAP),
        .MAX_GAP    (MAX_GAP),
        .LOCK_CNT   (LOCK_CNT),
        .CBITS      (CBITS),
        .TBITS      (TBITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .clr        (clr),
        .locked     (locked),
        .fault      (fault),
        .early      (early),
        .late       (late),
        .gap_cnt    (gap_cnt),
        .tick_count (tick_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic t, input logic c, input logic r);
        tick = t;
        clr  = c;
        rst  = r;
        @(posedge clk);
        #1;
        tick = 1'b0;
        clr  = 1'b0;
        rst  = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic tickAfter(input int gap);
        idleCycles(gap - 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    function automatic int pickGap();
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel <= 5)      return int'($urandom_range(MIN_GAP, MAX_GAP));
        else if (sel <= 7) return int'($urandom_range(1, MIN_GAP - 1));
        else if (sel == 8) return MAX_GAP + 1;
        else               return int'($urandom_range(MAX_GAP + 2, 30));
    endfunction

    // Behavioural model: gaps are differences of cycle stamps, evaluated at each sampling edge.
    always @(posedge clk) begin
        int gap;
        cyc++;
        m_early = 0;
        m_late  = 0;
        if (rst) begin
            m_mode  = M_IDLE;
            m_goods = 0;
            m_tc    = 0;
        end else if (clr) begin
            m_mode  = M_IDLE;
            m_goods = 0;
        end else if (m_mode == M_IDLE) begin
            if (tick) begin
                m_mode  = M_ACQ;
                m_goods = 0;
                m_last  = cyc;
            end
        end else if (m_mode != M_FAULT) begin
            gap = cyc - m_last;
            if (tick) begin
                m_last = cyc;
                if (gap >= MIN_GAP && gap <= MAX_GAP) begin
                    if (m_mode == M_LOCK) begin
                        m_tc = (m_tc + 1) % (1 << TBITS);
                    end else begin
                        m_goods++;
                        if (m_goods == LOCK_CNT) m_mode = M_LOCK;
                    end
                end else if (gap < MIN_GAP) begin
                    m_early = 1;
                    if (m_mode == M_LOCK) m_mode = M_FAULT;
                    else m_goods = 0;
                end
            end else if (gap >= MAX_GAP + 1) begin
                m_late  = 1;
                m_mode  = (m_mode == M_LOCK) ? M_FAULT : M_IDLE;
                m_goods = 0;
            end
        end
        if (m_mode == M_ACQ || m_mode == M_LOCK) begin
            m_gap_out = (cyc - m_last < MAX_GAP) ? cyc - m_last : MAX_GAP;
        end else begin
            m_gap_out = 0;
        end
        model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("locked", 32'(locked), 32'(m_mode == M_LOCK));
            checkOutput("fault", 32'(fault), 32'(m_mode == M_FAULT));
            checkOutput("early", 32'(early), 32'(m_early));
            checkOutput("late", 32'(late), 32'(m_late));
            checkOutput("gap_cnt", 32'(gap_cnt), 32'(m_gap_out));
            checkOutput("tick_count", 32'(tick_count), 32'(m_tc));
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int countdown;
        logic rt, rc, rr;

        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("reset_locked", 32'(locked), 32'd0);
        checkOutput("reset_fault", 32'(fault), 32'd0);
        checkOutput("reset_gap", 32'(gap_cnt), 32'd0);
        checkOutput("reset_tcount", 32'(tick_count), 32'd0);

        // Lock on 10-cycle spacing: phase tick plus three good gaps.
        applyStimulus(1'b1, 1'b0, 1'b0);
        tickAfter(10);
        tickAfter(10);
        checkOutput("lock_not_yet", 32'(locked), 32'd0);
        tickAfter(10);
        checkOutput("lock_rise", 32'(locked), 32'd1);
        checkOutput("lock_no_early", 32'(early), 32'd0);

        // Early tick while locked.
        tickAfter(5);
        checkOutput("early_pulse", 32'(early), 32'd1);
        checkOutput("early_fault", 32'(fault), 32'd1);
        checkOutput("early_unlock", 32'(locked), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("early_one_cycle", 32'(early), 32'd0);
        tickAfter(10);
        checkOutput("fault_sticky", 32'(fault), 32'd1);
        checkOutput("fault_gap_held", 32'(gap_cnt), 32'd0);

        // clr together with a tick: tick ignored, then relock.
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("clr_fault", 32'(fault), 32'd0);
        checkOutput("clr_gap", 32'(gap_cnt), 32'd0);
        tickAfter(4);
        tickAfter(10);
        tickAfter(10);
        checkOutput("relock_not_yet", 32'(locked), 32'd1 - 32'd1);
        tickAfter(10);
        checkOutput("relock", 32'(locked), 32'd1);

        // Ticks stop: gap_cnt saturates at MAX_GAP, then the timeout.
        idleCycles(MAX_GAP);
        checkOutput("sat_gap", 32'(gap_cnt), 32'(MAX_GAP));
        checkOutput("late_not_yet", 32'(late), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("late_pulse", 32'(late), 32'd1);
        checkOutput("late_fault", 32'(fault), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("clr_to_idle", 32'(fault), 32'd0);

        // Acquire with 10, 6, 10, 10, 10.
        applyStimulus(1'b1, 1'b0, 1'b0);
        tickAfter(10);
        tickAfter(6);
        checkOutput("acq_early", 32'(early), 32'd1);
        checkOutput("acq_no_fault", 32'(fault), 32'd0);
        tickAfter(10);
        tickAfter(10);
        checkOutput("acq_not_locked", 32'(locked), 32'd0);
        tickAfter(10);
        checkOutput("acq_locked", 32'(locked), 32'd1);

        // 17 good ticks while locked wraps the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) tickAfter(10);
        checkOutput("tcount_wrap", 32'(tick_count), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rst_locked", 32'(locked), 32'd0);
        checkOutput("rst_tcount", 32'(tick_count), 32'd0);
        checkOutput("rst_gap", 32'(gap_cnt), 32'd0);

        // Randomized traffic with occasional clr and rst.
        countdown = 10;
        for (int i = 0; i < 6000; i++) begin
            rr = ($urandom_range(0, 599) == 0);
            rc = ($urandom_range(0, 199) == 0);
            rt = 1'b0;
            if (countdown <= 1) begin
                rt = 1'b1;
                countdown = pickGap();
            end else begin
                countdown--;
            end
            applyStimulus(rt, rc, rr);
        end

        idleCycles(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tick_watchdog.md
# tick_watchdog

Downstream monitor for the periodic one-cycle tick produced by the delay/timer stage. It measures the spacing between consecutive ticks and acquires lock after a run of in-window gaps. Once locked, an early or missing tick raises a sticky fault. Its outputs feed the system health/status logic and the formal property set, which checks liveness of ticks and absence of spurious faults.

## Interface
- MIN_GAP, 17400: smallest legal tick-to-tick spacing, in cycles.
- MAX_GAP, 17600: largest legal spacing, in cycles. MIN_GAP ≤ MAX_GAP.
- LOCK_CNT, 4: number of consecutive legal gaps required to enter LOCKED.
- CBITS, 15: gap counter width. Must satisfy 2^CBITS > MAX_GAP.
- TBITS, 8: width of the good-tick counter.
- clk  in  1  clock; all logic is on posedge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle pulse from the upstream timer.
- clr  in  1  clears FAULT and returns to IDLE.
- locked  out  1  high while state is LOCKED.
- fault  out  1  sticky; high while state is FAULT.
- early  out  1  one-cycle pulse: a tick arrived with gap < MIN_GAP.
- late  out  1  one-cycle pulse: gap reached MAX_GAP with no tick.
- gap_cnt  out  CBITS  cycles elapsed since the last tick.
- tick_count  out  TBITS  good ticks counted while LOCKED; wraps modulo 2^TBITS.

## Operation
- Gap measure: in a cycle where tick=1, the gap is gap_cnt+1. Compute this in CBITS+1 bits so there is no overflow.
- gap_cnt update:
  - Cleared to 0 on the cycle after any tick.
  - Otherwise increments by 1, saturating at MAX_GAP.
  - Held at 0 in IDLE and FAULT.
- Classification, in a tick cycle:
  - good: MIN_GAP ≤ gap ≤ MAX_GAP.
  - early: gap < MIN_GAP.
- Timeout: a cycle with tick=0 and gap_cnt == MAX_GAP. No tick has arrived within MAX_GAP cycles.
- FSM states: IDLE, ACQUIRE, LOCKED, FAULT. A good-gap counter good_cnt (0..LOCK_CNT) is held internally.
  - IDLE: tick → ACQUIRE with good_cnt=0. This first tick only sets the phase; it is not classified.
  - ACQUIRE:
    - good tick → good_cnt+1; on reaching LOCK_CNT → LOCKED.
    - early tick → pulse early, good_cnt=0, stay in ACQUIRE. The gap restarts from this tick.
    - timeout → pulse late, go to IDLE.
  - LOCKED:
    - good tick → tick_count+1.
    - early tick → pulse early, go to FAULT.
    - timeout → pulse late, go to FAULT.
  - FAULT: sticky. Ignores tick. clr → IDLE.
- Priority per cycle: rst > clr > tick/timeout. clr in any state returns to IDLE and zeroes good_cnt. clr does not clear tick_count.
- tick and timeout cannot coincide: timeout requires tick=0.

## Timing
- Every output is registered. Each value reflects the cycle in which the event was sampled and is visible on the following cycle.
- Reset values:
  - state=IDLE.
  - locked=0, fault=0, early=0, late=0.
  - gap_cnt=0, tick_count=0, good_cnt=0.
- rst mid-operation, including during LOCKED or FAULT, forces the reset values on the next edge.
- Lock latency: locked rises one cycle after the tick that completes the LOCK_CNT-th good gap.
- Fault latency: fault and early/late rise one cycle after the offending tick or timeout cycle.
- early and late are high for exactly one cycle per event.
- tick_count wraps from 2^TBITS−1 to 0 with no flag.

## Structure
- Package tick_watchdog_pkg holds:
  - the state enum type (IDLE, ACQUIRE, LOCKED, FAULT);
  - the default parameter constants;
  - an elaboration-time check of CBITS against MAX_GAP.
- One sub-module, tick_gap_timer, implements the gap counter. It reports tick-time classification (good/early) and the timeout strobe.
- The FSM, good_cnt, tick_count and output registers live in tick_watchdog.

## Test plan
Bench parameters: MIN_GAP=8, MAX_GAP=12, LOCK_CNT=3, TBITS=4.
- Reset release, then ticks every 10 cycles → locked=1 one cycle after the 4th tick; fault=0, early and late never pulse.
- Locked, then the next tick 5 cycles after the previous one → early pulses once, fault=1, locked=0; later ticks are ignored.
- Locked, then ticks stop → late pulses 12 cycles after the last tick (plus one cycle for registering), fault=1.
- FAULT, then clr asserted together with a tick → next state is IDLE and the tick is ignored; re-lock after three further 10-cycle gaps.
- ACQUIRE, then gaps of 10, 6, 10, 10, 10 → early pulses on the 6-cycle gap; locked=1 only after three good gaps counted from that early tick.
- Locked with 17 more good ticks → tick_count wraps to 1. Separately, rst asserted mid-LOCKED → all outputs 0 on the next cycle.
